// File: rtl/truth_table_sweeper.sv
// Exhaustive 4-input stimulus sweep around a combinational block.
// Captures y per vector into a 16-bit truth table and a ones count.
module truth_table_sweeper #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        g,
  output logic        t,
  output logic        u,
  output logic        e,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, DRIVE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   tt_q, tt_d;
  logic [4:0]    ones_q, ones_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      hold_q  <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        vec_d = '0;
        if (start && !abort) begin
          state_d = DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          done_d  = 1'b0;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      DRIVE: begin
        // abort beats a coincident final sample
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          hold_d  = '0;
          vec_d   = '0;
        end else if (hold_q == LAST) begin
          tt_d[idx_q] = y;
          ones_d      = ones_q + 5'(y);
          hold_d      = '0;
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            idx_d   = '0;
            vec_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
            vec_d = idx_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
  end

  always_comb begin
    busy         = (state_q == DRIVE);
    {g, t, u, e} = vec_q;
    done         = done_q;
    truth_table  = tt_q;
    ones_count   = ones_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench: the function block is a lookup of a 16-bit table fn,
// so the expected capture is fn masked to the vectors sampled.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, a_abort, a_y;
  logic        a_g, a_t, a_u, a_e, a_busy, a_done;
  logic [15:0] a_tt, a_fn;
  logic [4:0]  a_ones;
  logic [3:0]  a_vec;

  logic        b_start, b_abort, b_y;
  logic        b_g, b_t, b_u, b_e, b_busy, b_done;
  logic [15:0] b_tt, b_fn;
  logic [4:0]  b_ones;
  logic [3:0]  b_vec;

  assign a_vec = {a_g, a_t, a_u, a_e};
  assign b_vec = {b_g, b_t, b_u, b_e};
  assign a_y   = a_fn[a_vec];
  assign b_y   = b_fn[b_vec];

  truth_table_sweeper #(.HOLD_CYCLES(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .g(a_g), .t(a_t), .u(a_u), .e(a_e), .y(a_y),
    .busy(a_busy), .done(a_done),
    .truth_table(a_tt), .ones_count(a_ones)
  );

  truth_table_sweeper #(.HOLD_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .g(b_g), .t(b_t), .u(b_u), .e(b_e), .y(b_y),
    .busy(b_busy), .done(b_done),
    .truth_table(b_tt), .ones_count(b_ones)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return 32'(c);
  endfunction

  function automatic logic [15:0] mask(input int k);
    logic [31:0] m;
    m = (32'd1 << k) - 32'd1;
    return m[15:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // abort_n / restart_n: cycle after start to pulse, -1 for none
  task automatic run_a(input logic [15:0] fn, input int abort_n,
                       input int restart_n);
    int n;
    int k;
    int exp_n;
    bit seq_ok;
    a_fn = fn;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    chk("a_start_busy", 32'(a_busy), 32'd1);
    chk("a_start_done", 32'(a_done), 32'd0);
    chk("a_start_clr", {11'd0, a_ones, a_tt}, 32'd0);
    n = 0;
    seq_ok = 1'b1;
    while (a_busy && n < 400) begin
      if (a_vec != 4'(n / 10)) seq_ok = 1'b0;
      if (n == abort_n) a_abort = 1'b1;
      if (n == restart_n) a_start = 1'b1;
      tick;
      a_start = 1'b0;
      a_abort = 1'b0;
      n++;
    end
    exp_n = (abort_n >= 0) ? abort_n + 1 : 160;
    k     = (abort_n >= 0) ? abort_n / 10 : 16;
    chk("a_busy_len", 32'(n), 32'(exp_n));
    chk("a_vec_seq", 32'(seq_ok), 32'd1);
    chk("a_vec_idle", 32'(a_vec), 32'd0);
    chk("a_done", 32'(a_done), 32'(abort_n < 0));
    chk("a_table", 32'(a_tt), 32'(fn & mask(k)));
    chk("a_ones", 32'(a_ones), pop(fn & mask(k)));
    repeat (3) tick;
    chk("a_done_sticky", 32'(a_done), 32'(abort_n < 0));
  endtask

  initial begin
    int ab;
    int n;
    bit seq_ok;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_fn = 16'h6996;
    b_start = 1'b0; b_abort = 1'b0; b_fn = 16'h6996;
    #12;
    chk("rst_a", {a_busy, a_done, a_vec, a_ones, a_tt}, 32'd0);
    chk("rst_b", {b_busy, b_done, b_vec, b_ones, b_tt}, 32'd0);
    rst_n = 1'b1;
    tick;

    run_a(16'h6996, -1, -1);
    run_a(16'h8000, -1, -1);
    run_a(16'h6996, 55, -1);
    run_a(16'h6996, -1, 33);
    run_a(16'h6996, 159, -1);

    a_start = 1'b1;
    a_abort = 1'b1;
    tick;
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("idle_sa_busy", 32'(a_busy), 32'd0);
    chk("idle_sa_vec", 32'(a_vec), 32'd0);
    chk("idle_sa_tt", 32'(a_tt), 32'h6996 & 32'h7fff);

    repeat (6) begin
      ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 159));
      run_a(16'($urandom), ab, -1);
    end

    a_fn = 16'h6996;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    repeat (95) tick;
    chk("pre_rst_vec", 32'(a_vec), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {a_busy, a_done, a_vec, a_ones, a_tt}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 32'(a_busy), 32'd0);

    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    n = 0;
    seq_ok = 1'b1;
    while (b_busy && n < 100) begin
      if (b_vec != 4'(n)) seq_ok = 1'b0;
      tick;
      n++;
    end
    chk("b_busy_len", 32'(n), 32'd16);
    chk("b_vec_seq", 32'(seq_ok), 32'd1);
    chk("b_done", 32'(b_done), 32'd1);
    chk("b_table", 32'(b_tt), 32'h6996);
    chk("b_ones", 32'(b_ones), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
